// File: rtl/apu_mixer_pkg.sv
// apu_mixer_pkg
// Shared constants and helper functions for the parametrised APU stereo mixer.
// Holds the register address map (as functions of the routing byte count),
// the gain width, the constant bits returned by the CTRL register, and the
// width function for the per-side wave sums.
package apu_mixer_pkg;

  // Gain runs 0..8, so four bits are enough.
  localparam int GAIN_W = 4;

  // CTRL[6:4] always read back as ones.
  localparam logic [2:0] CTRL_ONES = 3'b111;

  // Register map: VOL at 0, routing bytes from 1 upward, CTRL just past them.
  localparam int ADDR_VOL        = 0;
  localparam int ADDR_ROUTE_BASE = 1;

  function automatic int route_bytes(input int nch);
    return (nch + 3) / 4;
  endfunction

  function automatic int addr_ctrl(input int rb);
    return rb + 1;
  endfunction

  // Smallest width that holds the sum of every channel at full scale.
  function automatic int sum_width(input int nch, input int wave_w);
    return $clog2(nch * ((1 << wave_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/apu_mix_gain_ramp.sv
// apu_mix_gain_ramp
// Per-side gain tracker. On each sample_tick the current gain moves toward
// the target.
//   Build macro APU_MIXER_RAMP_EN:
//     defined   - gain steps by exactly 1 toward the target per tick
//     undefined - gain loads the target directly on each tick
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   target       - desired gain (0..8)
//   sample_tick  - one-cycle sample strobe, the only time the gain moves
//   cur_gain     - registered current gain
module apu_mix_gain_ramp
  import apu_mixer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [GAIN_W-1:0] target,
  input  logic              sample_tick,
  output logic [GAIN_W-1:0] cur_gain
);

  logic [GAIN_W-1:0] gain_q, gain_d;

  always_comb begin
    gain_d = gain_q;
    if (sample_tick) begin
`ifdef APU_MIXER_RAMP_EN
      // One step per tick keeps volume changes from clicking.
      if (gain_q < target) begin
        gain_d = gain_q + GAIN_W'(1);
      end else if (gain_q > target) begin
        gain_d = gain_q - GAIN_W'(1);
      end
`else
      gain_d = target;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q <= '0;
    end else begin
      gain_q <= gain_d;
    end
  end

  assign cur_gain = gain_q;

endmodule

// File: rtl/apu_mixer_ramp.sv
// apu_mixer_ramp
// Parametrised stereo mixer: master volume, per-channel left/right routing
// and master-control registers; sums routed channel waves per side and
// scales each side by a gain that tracks the programmed volume.
// Optional feature macro APU_MIXER_RAMP_EN enables gain ramping (see
// apu_mix_gain_ramp); without it the gain jumps straight to the volume.
// Ports:
//   clk, reset               - system clock, synchronous active-high reset
//   cpu_en, addr, write,     - CPU register bus; writes commit on cpu_en & write
//   wdata, rdata               rdata is combinational from addr
//   ch_wave, ch_off          - channel waves and per-channel mutes (sampled on tick)
//   length_plays             - channel-active status, visible in CTRL[3:0]
//   sample_tick              - one-cycle sample strobe
//   sound_r, sound_l         - registered mixed samples, valid two cycles after tick
//   sound_valid              - one-cycle strobe marking a new sample pair
module apu_mixer_ramp
  import apu_mixer_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int WAVE_W = 4,
  parameter int RB     = route_bytes(NCH),
  parameter int ADDR_W = $clog2(RB + 2),
  parameter int SUM_W  = sum_width(NCH, WAVE_W),
  parameter int OUT_W  = SUM_W + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    write,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  input  logic [NCH*WAVE_W-1:0]   ch_wave,
  input  logic [NCH-1:0]          ch_off,
  input  logic [NCH-1:0]          length_plays,
  input  logic                    sample_tick,
  output logic [OUT_W-1:0]        sound_r,
  output logic [OUT_W-1:0]        sound_l,
  output logic                    sound_valid
);

  localparam int CTRL_A = addr_ctrl(RB);
  localparam int PAD_W  = NCH + 4;

  logic [7:0]       vol_q, vol_d;
  logic             apu_on_q, apu_on_d;
  logic [NCH-1:0]   route_r_q, route_r_d, route_l_q, route_l_d;
  logic [SUM_W-1:0] sum_r_q, sum_r_d, sum_l_q, sum_l_d;
  logic [SUM_W-1:0] acc_r, acc_l;
  logic             stage_q, stage_d;
  logic [OUT_W-1:0] sound_r_q, sound_r_d, sound_l_q, sound_l_d;
  logic             valid_q, valid_d;
  logic [GAIN_W-1:0] target_r, target_l, gain_r, gain_l;

  logic             wr_en;
  logic [PAD_W-1:0] route_r_pad, route_l_pad, lp_pad;
  logic             unused_pad;

  assign wr_en = cpu_en & write;

  // Zero-padded copies let partial routing bytes and short length_plays
  // read back with zeros in the missing channel positions.
  assign route_r_pad = {4'b0000, route_r_q};
  assign route_l_pad = {4'b0000, route_l_q};
  assign lp_pad      = {4'b0000, length_plays};
  assign unused_pad  = ^{route_r_pad[PAD_W-1:4*RB], route_l_pad[PAD_W-1:4*RB],
                         lp_pad[PAD_W-1:4]};

  // Register writes. CTRL is always writable; clearing apu_on wipes the
  // volume and routing on the same edge.
  always_comb begin
    vol_d     = vol_q;
    apu_on_d  = apu_on_q;
    route_r_d = route_r_q;
    route_l_d = route_l_q;
    if (wr_en) begin
      if (addr == ADDR_W'(CTRL_A)) begin
        apu_on_d = wdata[7];
        if (!wdata[7]) begin
          vol_d     = '0;
          route_r_d = '0;
          route_l_d = '0;
        end
      end else if (apu_on_q) begin
        if (addr == ADDR_W'(ADDR_VOL)) begin
          vol_d = wdata;
        end
        for (int k = 0; k < NCH; k++) begin
          if (addr == ADDR_W'(ADDR_ROUTE_BASE + k / 4)) begin
            route_r_d[k] = wdata[k % 4];
            route_l_d[k] = wdata[4 + k % 4];
          end
        end
      end
    end
  end

  // Register read mux.
  always_comb begin
    rdata = 8'h00;
    if (addr == ADDR_W'(ADDR_VOL)) begin
      rdata = vol_q;
    end else if (addr == ADDR_W'(CTRL_A)) begin
      rdata = {apu_on_q, CTRL_ONES, lp_pad[3:0]};
    end
    for (int b = 0; b < RB; b++) begin
      if (addr == ADDR_W'(ADDR_ROUTE_BASE + b)) begin
        rdata = {route_l_pad[4*b +: 4], route_r_pad[4*b +: 4]};
      end
    end
  end

  // Per-side sums of enabled channels; SUM_W is sized so this never wraps.
  always_comb begin
    acc_r = '0;
    acc_l = '0;
    for (int k = 0; k < NCH; k++) begin
      if (route_r_q[k] & ~ch_off[k]) begin
        acc_r = acc_r + SUM_W'(ch_wave[k*WAVE_W +: WAVE_W]);
      end
      if (route_l_q[k] & ~ch_off[k]) begin
        acc_l = acc_l + SUM_W'(ch_wave[k*WAVE_W +: WAVE_W]);
      end
    end
  end

  // Targets come from registered state, so a write landing with the tick
  // only affects the next frame.
  assign target_r = apu_on_q ? ({1'b0, vol_q[2:0]} + GAIN_W'(1)) : '0;
  assign target_l = apu_on_q ? ({1'b0, vol_q[6:4]} + GAIN_W'(1)) : '0;

  apu_mix_gain_ramp u_gain_r (
    .clk         (clk),
    .reset       (reset),
    .target      (target_r),
    .sample_tick (sample_tick),
    .cur_gain    (gain_r)
  );

  apu_mix_gain_ramp u_gain_l (
    .clk         (clk),
    .reset       (reset),
    .target      (target_l),
    .sample_tick (sample_tick),
    .cur_gain    (gain_l)
  );

  // Two-stage pipeline: tick captures sums/steps gain, next cycle registers
  // the products. A tick in the product cycle overlaps cleanly because the
  // product uses the old sums while the new ones are captured.
  always_comb begin
    sum_r_d   = sample_tick ? acc_r : sum_r_q;
    sum_l_d   = sample_tick ? acc_l : sum_l_q;
    stage_d   = sample_tick;
    valid_d   = stage_q;
    sound_r_d = stage_q ? OUT_W'(sum_r_q) * OUT_W'(gain_r) : sound_r_q;
    sound_l_d = stage_q ? OUT_W'(sum_l_q) * OUT_W'(gain_l) : sound_l_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vol_q     <= '0;
      apu_on_q  <= 1'b0;
      route_r_q <= '0;
      route_l_q <= '0;
      sum_r_q   <= '0;
      sum_l_q   <= '0;
      stage_q   <= 1'b0;
      valid_q   <= 1'b0;
      sound_r_q <= '0;
      sound_l_q <= '0;
    end else begin
      vol_q     <= vol_d;
      apu_on_q  <= apu_on_d;
      route_r_q <= route_r_d;
      route_l_q <= route_l_d;
      sum_r_q   <= sum_r_d;
      sum_l_q   <= sum_l_d;
      stage_q   <= stage_d;
      valid_q   <= valid_d;
      sound_r_q <= sound_r_d;
      sound_l_q <= sound_l_d;
    end
  end

  assign sound_r     = sound_r_q;
  assign sound_l     = sound_l_q;
  assign sound_valid = valid_q;

endmodule

// File: tb/tb_apu_mixer_ramp.sv
// tb_apu_mixer_ramp
// Directed bench for apu_mixer_ramp: a 4-channel instance for the main
// scenarios and a 6-channel instance for partial routing bytes. Expected
// values follow APU_MIXER_RAMP_EN (ramping) when defined, direct load when not.
module tb_apu_mixer_ramp;

`ifdef APU_MIXER_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        cpu_en = 0, write = 0, sample_tick = 0;
  logic [1:0]  addr = 0;
  logic [7:0]  wdata = 0, rdata;
  logic [15:0] ch_wave = 0;
  logic [3:0]  ch_off = 0, length_plays = 0;
  logic [8:0]  sound_r, sound_l;
  logic        sound_valid;

  // 6-channel instance
  logic        cpu_en6 = 0, write6 = 0, sample_tick6 = 0;
  logic [1:0]  addr6 = 0;
  logic [7:0]  wdata6 = 0, rdata6;
  logic [23:0] ch_wave6 = 0;
  logic [5:0]  ch_off6 = 0, lp6 = 0;
  logic [9:0]  sound_r6, sound_l6;
  logic        sound_valid6;

  int errors = 0;
  int checks = 0;

  apu_mixer_ramp #(.NCH(4), .WAVE_W(4)) dut4 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .addr(addr), .write(write),
    .wdata(wdata), .rdata(rdata), .ch_wave(ch_wave), .ch_off(ch_off),
    .length_plays(length_plays), .sample_tick(sample_tick),
    .sound_r(sound_r), .sound_l(sound_l), .sound_valid(sound_valid)
  );

  apu_mixer_ramp #(.NCH(6), .WAVE_W(4)) dut6 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en6), .addr(addr6), .write(write6),
    .wdata(wdata6), .rdata(rdata6), .ch_wave(ch_wave6), .ch_off(ch_off6),
    .length_plays(lp6), .sample_tick(sample_tick6),
    .sound_r(sound_r6), .sound_l(sound_l6), .sound_valid(sound_valid6)
  );

  task automatic wr4(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_en = 1; write = 1; addr = a; wdata = d;
    @(negedge clk);
    cpu_en = 0; write = 0;
    $display("wr4 addr=%0d data=%02h", a, d);
  endtask

  task automatic rd4(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rdata;
    $display("rd4 addr=%0d data=%02h", a, d);
  endtask

  task automatic wr6(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_en6 = 1; write6 = 1; addr6 = a; wdata6 = d;
    @(negedge clk);
    cpu_en6 = 0; write6 = 0;
    $display("wr6 addr=%0d data=%02h", a, d);
  endtask

  task automatic rd6(input logic [1:0] a, output logic [7:0] d);
    addr6 = a;
    #1;
    d = rdata6;
    $display("rd6 addr=%0d data=%02h", a, d);
  endtask

  // One sample frame: tick, then observe valid in cycle 1 and cycle 2.
  task automatic frame4(output logic v1, output logic v2,
                        output logic [8:0] r, output logic [8:0] l);
    @(negedge clk) sample_tick = 1;
    @(negedge clk) sample_tick = 0;
    v1 = sound_valid;
    @(negedge clk);
    v2 = sound_valid; r = sound_r; l = sound_l;
    $display("frame4 valid=%0b%0b r=%0d l=%0d", v1, v2, r, l);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++; if (sound_r !== 9'd0 || sound_l !== 9'd0) begin
      errors++; $display("FAIL reset_sound r=%0d l=%0d want 0", sound_r, sound_l); end
    checks++; if (sound_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", sound_valid); end
    rd4(0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_vol got %02h want 00", d); end
    rd4(2, d);
    checks++; if (d !== 8'h70) begin errors++; $display("FAIL reset_ctrl got %02h want 70", d); end
    length_plays = 4'b1010;
    rd4(2, d);
    checks++; if (d !== 8'h7A) begin errors++; $display("FAIL ctrl_lp got %02h want 7a", d); end
    length_plays = 0;
    rd4(3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped got %02h want 00", d); end
    wr4(0, 8'h55);
    rd4(0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL vol_when_off got %02h want 00", d); end
    // write strobe without cpu_en must not commit
    @(negedge clk);
    cpu_en = 0; write = 1; addr = 2; wdata = 8'h80;
    @(negedge clk);
    write = 0;
    rd4(2, d);
    checks++; if (d !== 8'h70) begin errors++; $display("FAIL no_cpu_en got %02h want 70", d); end
  endtask

  task automatic test_ramp_up;
    logic [7:0] d;
    logic v1, v2;
    logic [8:0] r, l, e;
    wr4(2, 8'h80);
    wr4(0, 8'h77);
    wr4(1, 8'hFF);
    ch_wave = 16'hFFFF;
    rd4(0, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL vol_rb got %02h want 77", d); end
    rd4(1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL route_rb got %02h want ff", d); end
    rd4(2, d);
    checks++; if (d !== 8'hF0) begin errors++; $display("FAIL ctrl_on got %02h want f0", d); end
    for (int i = 1; i <= 10; i++) begin
      e = RAMP ? 9'(60 * ((i < 8) ? i : 8)) : 9'd480;
      frame4(v1, v2, r, l);
      checks++; if (v1 !== 1'b0 || v2 !== 1'b1) begin
        errors++; $display("FAIL ramp_valid%0d got %b%b want 01", i, v1, v2); end
      checks++; if (r !== e || l !== e) begin
        errors++; $display("FAIL ramp_up%0d r=%0d l=%0d want %0d", i, r, l, e); end
    end
    @(negedge clk);
    checks++; if (sound_valid !== 1'b0 || sound_r !== 9'd480) begin
      errors++; $display("FAIL hold valid=%b r=%0d want 0/480", sound_valid, sound_r); end
  endtask

  task automatic test_ch_off;
    logic v1, v2;
    logic [8:0] r, l;
    ch_off = 4'b0100;
    frame4(v1, v2, r, l);
    ch_off = 0;
    checks++; if (v2 !== 1'b1 || r !== 9'd360 || l !== 9'd360) begin
      errors++; $display("FAIL ch_off v=%b r=%0d l=%0d want 1/360/360", v2, r, l); end
  endtask

  task automatic test_write_with_tick;
    logic v1, v2;
    logic [8:0] r, l;
    @(negedge clk);
    sample_tick = 1; cpu_en = 1; write = 1; addr = 1; wdata = 8'h00;
    @(negedge clk);
    sample_tick = 0; cpu_en = 0; write = 0;
    v1 = sound_valid;
    @(negedge clk);
    $display("wr_tick valid=%0b%0b r=%0d l=%0d", v1, sound_valid, sound_r, sound_l);
    checks++; if (v1 !== 1'b0 || sound_valid !== 1'b1 || sound_r !== 9'd480 || sound_l !== 9'd480) begin
      errors++; $display("FAIL wr_tick v=%b%b r=%0d l=%0d want 01/480/480", v1, sound_valid, sound_r, sound_l); end
    frame4(v1, v2, r, l);
    checks++; if (r !== 9'd0 || l !== 9'd0) begin
      errors++; $display("FAIL after_unroute r=%0d l=%0d want 0", r, l); end
    wr4(1, 8'hFF);
  endtask

  task automatic test_back_to_back;
    logic v1, va, vb, vc;
    logic [8:0] ra, la, rb, lb;
    @(negedge clk) sample_tick = 1; ch_off = 0;
    @(negedge clk) ch_off = 4'b0100;
    v1 = sound_valid;
    @(negedge clk) sample_tick = 0; ch_off = 0;
    va = sound_valid; ra = sound_r; la = sound_l;
    @(negedge clk);
    vb = sound_valid; rb = sound_r; lb = sound_l;
    @(negedge clk);
    vc = sound_valid;
    $display("b2b valid=%0b%0b%0b%0b r=%0d,%0d l=%0d,%0d", v1, va, vb, vc, ra, rb, la, lb);
    checks++; if ({v1, va, vb, vc} !== 4'b0110) begin
      errors++; $display("FAIL b2b_valid got %b%b%b%b want 0110", v1, va, vb, vc); end
    checks++; if (ra !== 9'd480 || la !== 9'd480) begin
      errors++; $display("FAIL b2b_first r=%0d l=%0d want 480", ra, la); end
    checks++; if (rb !== 9'd360 || lb !== 9'd360) begin
      errors++; $display("FAIL b2b_second r=%0d l=%0d want 360", rb, lb); end
  endtask

  task automatic test_ramp_down;
    logic [7:0] d;
    logic v1, v2;
    logic [8:0] r, l, e;
    wr4(0, 8'h70);
    rd4(0, d);
    checks++; if (d !== 8'h70) begin errors++; $display("FAIL vol70 got %02h want 70", d); end
    for (int i = 1; i <= 8; i++) begin
      e = RAMP ? 9'(60 * ((8 - i > 1) ? 8 - i : 1)) : 9'd60;
      frame4(v1, v2, r, l);
      checks++; if (r !== e) begin
        errors++; $display("FAIL ramp_down%0d r=%0d want %0d", i, r, e); end
      checks++; if (l !== 9'd480) begin
        errors++; $display("FAIL left_hold%0d l=%0d want 480", i, l); end
    end
  endtask

  task automatic test_ctrl_clear;
    logic [7:0] d;
    logic v1, v2;
    logic [8:0] r, l;
    wr4(2, 8'h00);
    rd4(0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL clr_vol got %02h want 00", d); end
    rd4(1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL clr_route got %02h want 00", d); end
    rd4(2, d);
    checks++; if (d !== 8'h70) begin errors++; $display("FAIL clr_ctrl got %02h want 70", d); end
    wr4(0, 8'h77);
    wr4(1, 8'hFF);
    rd4(0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL off_vol_wr got %02h want 00", d); end
    rd4(1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL off_route_wr got %02h want 00", d); end
    for (int i = 1; i <= 8; i++) begin
      frame4(v1, v2, r, l);
      checks++; if (v2 !== 1'b1 || r !== 9'd0 || l !== 9'd0) begin
        errors++; $display("FAIL off_frame%0d v=%b r=%0d l=%0d want 1/0/0", i, v2, r, l); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    wr4(2, 8'h80);
    wr4(0, 8'h77);
    wr4(1, 8'hFF);
    @(negedge clk) sample_tick = 1;
    @(negedge clk) sample_tick = 0; reset = 1;
    @(negedge clk) reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (sound_valid !== 1'b0 || sound_r !== 9'd0) begin
        errors++; $display("FAIL reset_mid%0d v=%b r=%0d want 0/0", i, sound_valid, sound_r); end
    end
    rd4(0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_vol got %02h want 00", d); end
  endtask

  task automatic test_nch6;
    logic [7:0] d;
    logic v1, v2;
    logic [9:0] r, l;
    ch_wave6 = {4'h3, 4'h3, 16'hFFFF};
    lp6 = 6'h3F;
    wr6(3, 8'h80);
    wr6(2, 8'hFF);
    rd6(2, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL n6_route2 got %02h want 33", d); end
    rd6(1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL n6_route1 got %02h want 00", d); end
    rd6(3, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL n6_ctrl got %02h want ff", d); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk) sample_tick6 = 1;
      @(negedge clk) sample_tick6 = 0;
      v1 = sound_valid6;
      @(negedge clk);
      v2 = sound_valid6; r = sound_r6; l = sound_l6;
      $display("frame6 valid=%0b%0b r=%0d l=%0d", v1, v2, r, l);
      checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || r !== 10'd6 || l !== 10'd6) begin
        errors++; $display("FAIL n6_frame%0d v=%b%b r=%0d l=%0d want 01/6/6", i, v1, v2, r, l); end
    end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_ch_off;
    test_write_with_tick;
    test_back_to_back;
    test_ramp_down;
    test_ctrl_clear;
    test_reset_mid;
    test_nch6;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
